// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM test slice: default widths and the
// read-checker state encoding.
package sdram_test_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 23;
   localparam int DEF_LEN_W  = 9;
   localparam int ERR_CNT_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_STREAM,
      ST_DRAIN,
      ST_FINISH
   } state_t;
endpackage

// File: rtl/sdram_pattern_gen.sv
// Incrementing test pattern source: expected = seed + idx (wraps at DATA_W).
// Shared between the read checker and the write-pattern source.
module sdram_pattern_gen
   import sdram_test_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   input  logic [DATA_W-1:0] seed,
   output logic [LEN_W:0]    idx,
   output logic [DATA_W-1:0] expected
);

   logic [DATA_W-1:0] seed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_q <= '0;
         idx    <= '0;
      end else if (load) begin
         seed_q <= seed;
         idx    <= '0;
      end else if (advance) begin
         idx    <= idx + 1'b1;
      end
   end

   assign expected = seed_q + DATA_W'(idx);

endmodule

// File: rtl/sdram_read_checker.sv
// Issues one SDRAM burst read and checks the returned words against an
// incrementing pattern, reporting errors, first-mismatch details and timeout.
module sdram_read_checker
   import sdram_test_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sdram_init_done,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [LEN_W-1:0]     length,
   input  logic [DATA_W-1:0]    seed,
   output logic                 sdram_rd_req,
   output logic [ADDR_W-1:0]    sdram_rdaddr,
   output logic [LEN_W-1:0]     sdrd_byte,
   input  logic                 sdram_rd_ack,
   input  logic [DATA_W-1:0]    sdram_dout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [LEN_W-1:0]     first_err_idx,
   output logic [DATA_W-1:0]    first_err_data,
   output logic [DATA_W-1:0]    first_err_exp
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   state_t state, state_next;

   logic              accept, active, consume, last_word, to_fire;
   logic [LEN_W:0]    idx;
   logic [DATA_W-1:0] expected;
   logic [TO_W-1:0]   to_cnt;
   logic              drain_cnt;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data, s1_exp;
   logic [LEN_W-1:0]  s1_idx;

   sdram_pattern_gen #(
      .DATA_W(DATA_W),
      .LEN_W (LEN_W)
   ) u_pattern (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .advance (consume),
      .seed    (seed),
      .idx     (idx),
      .expected(expected)
   );

   // Acks count only while a read is outstanding; the burst ends on the length-th one.
   assign accept    = (state == ST_IDLE) && start && sdram_init_done;
   assign active    = (state == ST_REQ) || (state == ST_STREAM);
   assign consume   = active && sdram_rd_ack;
   assign last_word = consume && ((idx + 1'b1) == {1'b0, sdrd_byte});
   assign to_fire   = active && !sdram_rd_ack && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept) state_next = (length == '0) ? ST_FINISH : ST_REQ;
         ST_REQ,
         ST_STREAM: begin
            if (last_word || to_fire) state_next = ST_DRAIN;
            else if (consume)         state_next = ST_STREAM;
         end
         ST_DRAIN:  if (drain_cnt) state_next = ST_FINISH;
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Stage 1 of the compare pipeline: capture the consumed word with its expectation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_exp    <= '0;
         s1_idx    <= '0;
         drain_cnt <= 1'b0;
      end else begin
         s1_valid  <= consume;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
         if (consume) begin
            s1_data <= sdram_dout;
            s1_exp  <= expected;
            s1_idx  <= idx[LEN_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdram_rd_req   <= 1'b0;
         sdram_rdaddr   <= '0;
         sdrd_byte      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
         to_cnt         <= '0;
      end else if (accept) begin
         sdram_rdaddr   <= base_addr;
         sdrd_byte      <= length;
         sdram_rd_req   <= (length != '0);
         busy           <= 1'b1;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
         to_cnt         <= '0;
      end else begin
         if ((state == ST_REQ) && (consume || to_fire)) sdram_rd_req <= 1'b0;
         if (consume)     to_cnt <= '0;
         else if (active) to_cnt <= to_cnt + 1'b1;
         if (to_fire) timeout <= 1'b1;
         // Stage 2: a zero error count means this mismatch is the first one.
         if (s1_valid && (s1_data != s1_exp)) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (err_count == '0) begin
               first_err_idx  <= s1_idx;
               first_err_data <= s1_data;
               first_err_exp  <= s1_exp;
            end
         end
         if (state == ST_FINISH) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (err_count == '0) && !timeout;
         end
      end
   end

endmodule

// File: tb/tb_sdram_read_checker.sv
// Directed bench for sdram_read_checker: a pattern model fills a scoreboard
// at each start, and each finished check is popped and compared.
module tb_sdram_read_checker;

   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 23;
   localparam int LEN_W       = 9;
   localparam int TIMEOUT_CYC = 1024;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sdram_init_done;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic [DATA_W-1:0] seed;
   logic              sdram_rd_req;
   logic [ADDR_W-1:0] sdram_rdaddr;
   logic [LEN_W-1:0]  sdrd_byte;
   logic              sdram_rd_ack;
   logic [DATA_W-1:0] sdram_dout;
   logic              busy;
   logic              done;
   logic              pass;
   logic              timeout;
   logic [15:0]       err_count;
   logic [LEN_W-1:0]  first_err_idx;
   logic [DATA_W-1:0] first_err_data;
   logic [DATA_W-1:0] first_err_exp;

   always #5 clk = ~clk;

   sdram_read_checker #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .LEN_W      (LEN_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sdram_init_done(sdram_init_done),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .seed           (seed),
      .sdram_rd_req   (sdram_rd_req),
      .sdram_rdaddr   (sdram_rdaddr),
      .sdrd_byte      (sdrd_byte),
      .sdram_rd_ack   (sdram_rd_ack),
      .sdram_dout     (sdram_dout),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .err_count      (err_count),
      .first_err_idx  (first_err_idx),
      .first_err_data (first_err_data),
      .first_err_exp  (first_err_exp)
   );

   typedef struct {
      logic              pass_e;
      logic              timeout_e;
      logic [15:0]       err_e;
      logic [LEN_W-1:0]  idx_e;
      logic [DATA_W-1:0] data_e;
      logic [DATA_W-1:0] exp_e;
      int                req_e;
      int                lat_e;
      logic [ADDR_W-1:0] addr_e;
      logic [LEN_W-1:0]  len_e;
   } result_t;

   result_t           sb[$];
   logic [DATA_W-1:0] burstData [512];
   int                reqCount = 0;
   int                reqBase;
   int                doneLat;
   int                passCount = 0;
   int                totalChecks = 0;
   int                failCount = 0;

   // Counts request-high cycles, sampled mid-cycle.
   always @(negedge clk) if (sdram_rd_req) reqCount = reqCount + 1;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalChecks++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fillPattern(input logic [DATA_W-1:0] sd, input int len);
      for (int i = 0; i < len; i++) burstData[i] = sd + 16'(i);
   endtask

   function automatic result_t model(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                     input logic [DATA_W-1:0] sd, input int latency, input bit noAck);
      result_t r;
      logic [DATA_W-1:0] e;
      r.err_e = '0; r.idx_e = '0; r.data_e = '0; r.exp_e = '0;
      r.timeout_e = noAck && (len != 0);
      if (!noAck) begin
         for (int i = 0; i < int'(len); i++) begin
            e = sd + 16'(i);
            if (burstData[i] !== e) begin
               if (r.err_e == 0) begin
                  r.idx_e  = LEN_W'(i);
                  r.data_e = burstData[i];
                  r.exp_e  = e;
               end
               r.err_e = r.err_e + 1'b1;
            end
         end
      end
      r.pass_e = !r.timeout_e && (r.err_e == 0);
      r.req_e  = (len == 0) ? 0 : (noAck ? TIMEOUT_CYC : latency + 1);
      r.lat_e  = (len == 0 || noAck) ? -1 : 3;
      r.addr_e = addr;
      r.len_e  = len;
      return r;
   endfunction

   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                input logic [DATA_W-1:0] sd, input int latency, input int gap,
                                input int extra, input bit noAck, input int midStartAt);
      int k;
      sb.push_back(model(addr, len, sd, latency, noAck));
      reqBase = reqCount;
      doneLat = -1;
      base_addr = addr; length = len; seed = sd; start = 1'b1;
      tick;
      start = 1'b0;
      k = 0;
      if (len == 0 || noAck) begin
         while (!done && k < 3000) begin tick; k++; end
      end else begin
         repeat (latency) tick;
         for (int i = 0; i < int'(len); i++) begin
            sdram_rd_ack = 1'b1;
            sdram_dout   = burstData[i];
            if (i == midStartAt) begin
               start = 1'b1; length = 9'd7; seed = 16'h1234; base_addr = 23'h7;
            end
            tick;
            start = 1'b0;
            if (gap > 0 && i < int'(len) - 1) begin
               sdram_rd_ack = 1'b0;
               sdram_dout   = '0;
               repeat (gap) tick;
            end
         end
         // Trailing acks (if any) must be ignored once the burst is complete.
         while (!done && k < 50) begin
            sdram_rd_ack = (k < extra);
            sdram_dout   = 16'hDEAD;
            tick;
            k++;
         end
         doneLat = k;
         sdram_rd_ack = 1'b0;
      end
   endtask

   task automatic checkResult(input string name);
      result_t r;
      r = sb.pop_front();
      checkOutput({name, ".done"},      32'(done),           32'd1);
      checkOutput({name, ".busy"},      32'(busy),           32'd0);
      checkOutput({name, ".pass"},      32'(pass),           32'(r.pass_e));
      checkOutput({name, ".timeout"},   32'(timeout),        32'(r.timeout_e));
      checkOutput({name, ".err_count"}, 32'(err_count),      32'(r.err_e));
      checkOutput({name, ".err_idx"},   32'(first_err_idx),  32'(r.idx_e));
      checkOutput({name, ".err_data"},  32'(first_err_data), 32'(r.data_e));
      checkOutput({name, ".err_exp"},   32'(first_err_exp),  32'(r.exp_e));
      checkOutput({name, ".req_cyc"},   32'(reqCount - reqBase), 32'(r.req_e));
      checkOutput({name, ".rdaddr"},    32'(sdram_rdaddr),   32'(r.addr_e));
      checkOutput({name, ".rd_len"},    32'(sdrd_byte),      32'(r.len_e));
      if (r.lat_e >= 0) checkOutput({name, ".done_lat"}, 32'(doneLat), 32'(r.lat_e));
      tick;
   endtask

   initial begin
      rst_n = 1'b0; sdram_init_done = 1'b0; start = 1'b0;
      base_addr = '0; length = '0; seed = '0;
      sdram_rd_ack = 1'b0; sdram_dout = '0;
      repeat (3) tick;
      checkOutput("rst.busy",      32'(busy),          32'd0);
      checkOutput("rst.done",      32'(done),          32'd0);
      checkOutput("rst.pass",      32'(pass),          32'd0);
      checkOutput("rst.rd_req",    32'(sdram_rd_req),  32'd0);
      checkOutput("rst.err_count", 32'(err_count),     32'd0);
      rst_n = 1'b1;
      tick;

      $display("[TB] start before init done");
      reqBase = reqCount;
      base_addr = 23'h55; length = 9'd16; seed = 16'h0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
      checkOutput("noinit.busy", 32'(busy), 32'd0);
      checkOutput("noinit.req",  32'(reqCount - reqBase), 32'd0);
      sdram_init_done = 1'b1;
      tick;

      $display("[TB] ideal 256-word burst");
      fillPattern(16'h0000, 256);
      applyStimulus(23'h000100, 9'd256, 16'h0000, 5, 0, 0, 1'b0, -1);
      checkResult("ideal");

      $display("[TB] two corrupted words");
      fillPattern(16'h0000, 256);
      burstData[17]  = 16'hBEEF;
      burstData[200] = 16'h0000;
      applyStimulus(23'h000100, 9'd256, 16'h0000, 5, 0, 0, 1'b0, -1);
      checkResult("errors");

      $display("[TB] seed wrap with ack gaps");
      fillPattern(16'hFFFE, 4);
      applyStimulus(23'h000010, 9'd4, 16'hFFFE, 2, 3, 0, 1'b0, -1);
      checkResult("wrap");

      $display("[TB] no ack timeout");
      applyStimulus(23'h000020, 9'd8, 16'h1111, 0, 0, 0, 1'b1, -1);
      checkResult("timeout");

      $display("[TB] zero length");
      applyStimulus(23'h000030, 9'd0, 16'h2222, 0, 0, 0, 1'b0, -1);
      checkResult("len0");

      $display("[TB] extra acks and start while busy");
      fillPattern(16'h0100, 256);
      applyStimulus(23'h000400, 9'd256, 16'h0100, 3, 0, 3, 1'b0, 50);
      checkResult("ignored");

      $display("[TB] reset mid-stream");
      fillPattern(16'h0055, 256);
      burstData[10] = 16'h0BAD;
      base_addr = 23'h000500; length = 9'd256; seed = 16'h0055; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (2) tick;
      for (int i = 0; i <= 100; i++) begin
         sdram_rd_ack = 1'b1;
         sdram_dout   = burstData[i];
         tick;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.busy",      32'(busy),           32'd0);
      checkOutput("midrst.rd_req",    32'(sdram_rd_req),   32'd0);
      checkOutput("midrst.done",      32'(done),           32'd0);
      checkOutput("midrst.err_count", 32'(err_count),      32'd0);
      checkOutput("midrst.err_idx",   32'(first_err_idx),  32'd0);
      checkOutput("midrst.err_data",  32'(first_err_data), 32'd0);
      checkOutput("midrst.rd_len",    32'(sdrd_byte),      32'd0);
      checkOutput("midrst.rdaddr",    32'(sdram_rdaddr),   32'd0);
      sdram_dout = 16'hDEAD;
      repeat (3) tick;
      rst_n = 1'b1;
      repeat (5) tick;
      sdram_rd_ack = 1'b0;
      tick;
      checkOutput("postrst.busy",      32'(busy),      32'd0);
      checkOutput("postrst.done",      32'(done),      32'd0);
      checkOutput("postrst.err_count", 32'(err_count), 32'd0);

      $display("[TB] full pass after reset");
      fillPattern(16'h0055, 256);
      applyStimulus(23'h000500, 9'd256, 16'h0055, 4, 0, 0, 1'b0, -1);
      checkResult("rerun");

      if (failCount != 0) $display("[TB] %0d comparison(s) failed", failCount);
      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
